store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write-side counterpart to the combinational instruction/load read port of main memory.
- Accepts byte, halfword and word stores from the execute stage over a valid/ready handshake.
- Steers each store's data onto byte lanes and generates byte enables.
- Buffers stores in a DEPTH-entry FIFO and drains them one per accepted cycle into the memory write port.
- Flags loads whose word address matches a pending store (read-after-write hazard) so the core can stall.

Parameters:
DEPTH, 4, number of buffered stores; power of two, at least 2
CW, $clog2(DEPTH)+1, width of count_o (derived; not to be overridden)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
st_valid_i  input  1  store request valid
st_ready_o  output  1  buffer can accept a store
st_addr_i  input  32  store byte address
st_data_i  input  32  store data, right-justified
st_size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved
st_misaligned_o  output  1  one-cycle pulse: previous accepted store was misaligned or reserved and was dropped
mem_wr_en_o  output  1  write request valid (head entry present)
mem_wr_addr_o  output  32  word-aligned write address, bits [1:0] = 00
mem_wr_data_o  output  32  lane-steered write data
mem_wr_be_o  output  4  byte enables, bit n = byte lane n
mem_wr_ready_i  input  1  memory accepts the write this cycle
ld_check_en_i  input  1  a load is being issued this cycle
ld_check_addr_i  input  32  load byte address
ld_hazard_o  output  1  load word address matches a buffered store
empty_o  output  1  no buffered stores
count_o  output  CW  number of buffered stores

Behaviour:
- Reset (rst_ni low, asynchronous), all FIFO state is discarded, including a store mid-drain:
  - count_o=0, empty_o=1, st_ready_o=1, st_misaligned_o=0.
  - mem_wr_en_o=0, mem_wr_addr_o=0, mem_wr_data_o=0, mem_wr_be_o=0, ld_hazard_o=0.
  - Read and write pointers return to 0.
- st_ready_o = (count_o != DEPTH). It is combinational from count only and does not depend on mem_wr_ready_i; a full buffer never accepts, even if a pop happens in the same cycle.
- Accept condition: st_valid_i && st_ready_o at the rising edge.
- Alignment check on accept:
  - Halfword with addr[0]=1, word with addr[1:0]!=0, and size 11 are all illegal.
  - An illegal store completes the handshake but is not enqueued.
  - st_misaligned_o is registered high for exactly the next cycle.
- Lane steering, with a = addr[1:0]; unused lanes are 0:
  - byte: data = {24'b0, d[7:0]} << 8*a; be = 4'b0001 << a
  - halfword: data = {16'b0, d[15:0]} << 16*a[1]; be = 4'b0011 << a
  - word: data = d; be = 4'b1111
- Each entry stores {addr[31:2], data, be}.
- Drain:
  - mem_wr_en_o = !empty_o.
  - mem_wr_addr_o, mem_wr_data_o and mem_wr_be_o come from the head entry through a mux only; there is no bypass from st_* inputs.
  - When the buffer is empty, mem_wr_* outputs are 0.
  - The head pops at an edge where mem_wr_en_o && mem_wr_ready_i.
- Latency: a store accepted at edge N into an empty buffer drives mem_wr_en_o in the cycle after N. Minimum store-to-memory latency is 1 cycle.
- Push and pop at the same edge (buffer not full): count unchanged, both pointers advance.
- Pointers are CW-1 bits and wrap modulo DEPTH. Order is strictly FIFO; entries are never merged or coalesced.
- Hazard:
  - ld_hazard_o = ld_check_en_i && (some valid entry's word address == ld_check_addr_i[31:2]). It is combinational.
  - The head entry being written this cycle counts as a match.
  - A store being accepted in the same cycle does not count.
  - Byte enables are ignored, so any overlap in the same word is a hazard.
- mem_wr_ready_i held low: the buffer holds its head and fills to DEPTH, then st_ready_o drops. No entry is lost or duplicated.
- count_o and empty_o are registered state. count_o ranges 0..DEPTH.

Test Plan:
- Reset/idle: release rst_ni, hold inputs low -> count_o=0, empty_o=1, st_ready_o=1, mem_wr_en_o=0; assert rst_ni low mid-drain -> all outputs return to reset values immediately.
- Lane steering with mem_wr_ready_i=1:
  - byte 0xAB to 0x1003 -> addr 0x1000, data 0xAB000000, be 1000, one cycle after accept.
  - halfword 0xBEEF to 0x2002 -> data 0xBEEF0000, be 1100.
  - word 0x12345678 to 0x3000 -> be 1111.
- Misaligned/reserved: word to 0x1001, halfword to 0x1005, size 11 -> each handshake completes, st_misaligned_o pulses for one cycle, count_o stays 0, no write issued.
- Backpressure/full: mem_wr_ready_i=0, push DEPTH+1 stores back-to-back -> st_ready_o low after the 4th, count_o=4. Release ready -> 4 writes drain in push order over 4 cycles, addresses wrap correctly. Then push and pop in the same cycle -> count_o unchanged.
- Hazard: buffer holds a store to 0x400. Load check at 0x402 -> ld_hazard_o=1; at 0x404 -> 0. A store accepted the same cycle to 0x404 -> still 0. After the 0x400 entry pops -> 0x402 check gives 0.
- Random stress: 10k random stores/ready/load checks against a reference queue model -> write sequence, data, be and hazard match exactly.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: aligns byte/halfword/word stores onto memory byte lanes, queues them
// in a small FIFO for the memory write port, and flags loads that hit a pending store.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          st_valid_i,
   output logic          st_ready_o,
   input  logic [31:0]   st_addr_i,
   input  logic [31:0]   st_data_i,
   input  logic [1:0]    st_size_i,
   output logic          st_misaligned_o,
   output logic          mem_wr_en_o,
   output logic [31:0]   mem_wr_addr_o,
   output logic [31:0]   mem_wr_data_o,
   output logic [3:0]    mem_wr_be_o,
   input  logic          mem_wr_ready_i,
   input  logic          ld_check_en_i,
   input  logic [31:0]   ld_check_addr_i,
   output logic          ld_hazard_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int PW = CW - 1;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   function automatic logic is_legal(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_BYTE: is_legal = 1'b1;
         SZ_HALF: is_legal = ~a[0];
         SZ_WORD: is_legal = (a == 2'b00);
         default: is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] steer_data(input logic [1:0] size, input logic [1:0] a,
                                              input logic [31:0] d);
      case (size)
         SZ_BYTE: steer_data = {24'b0, d[7:0]} << {a, 3'b000};
         SZ_HALF: steer_data = {16'b0, d[15:0]} << {a[1], 4'b0000};
         default: steer_data = d;
      endcase
   endfunction

   function automatic logic [3:0] steer_be(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_BYTE: steer_be = 4'b0001 << a;
         SZ_HALF: steer_be = 4'b0011 << a;
         default: steer_be = 4'b1111;
      endcase
   endfunction

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;
   logic          empty_q;
   logic          misaligned_q;
   logic [DEPTH-1:0] ent_vld;
   logic [29:0]   ent_addr [DEPTH];
   logic [31:0]   ent_data [DEPTH];
   logic [3:0]    ent_be   [DEPTH];

   logic accept, legal, push, pop, hit;
   logic unused_ld_low;

   assign unused_ld_low = ^ld_check_addr_i[1:0];

   // Ready depends only on occupancy so a full buffer never accepts, even while popping.
   assign st_ready_o  = (count_q != CW'(DEPTH));
   assign accept      = st_valid_i && st_ready_o;
   assign legal       = is_legal(st_size_i, st_addr_i[1:0]);
   assign push        = accept && legal;
   assign mem_wr_en_o = ~empty_q;
   assign pop         = mem_wr_en_o && mem_wr_ready_i;

   assign st_misaligned_o = misaligned_q;
   assign empty_o         = empty_q;
   assign count_o         = count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         empty_q      <= 1'b1;
         misaligned_q <= 1'b0;
         ent_vld      <= '0;
      end else begin
         misaligned_q <= accept && !legal;
         if (pop) begin
            ent_vld[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + PW'(1);
         end
         if (push) begin
            ent_vld[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10: begin
               count_q <= count_q + CW'(1);
               empty_q <= 1'b0;
            end
            2'b01: begin
               count_q <= count_q - CW'(1);
               empty_q <= (count_q == CW'(1));
            end
            default: ;
         endcase
      end
   end

   // Entry payload carries no reset; validity is tracked by ent_vld/count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         ent_addr[wr_ptr] <= st_addr_i[31:2];
         ent_data[wr_ptr] <= steer_data(st_size_i, st_addr_i[1:0], st_data_i);
         ent_be[wr_ptr]   <= steer_be(st_size_i, st_addr_i[1:0]);
      end
   end

   always_comb begin
      mem_wr_addr_o = '0;
      mem_wr_data_o = '0;
      mem_wr_be_o   = '0;
      if (!empty_q) begin
         mem_wr_addr_o = {ent_addr[rd_ptr], 2'b00};
         mem_wr_data_o = ent_data[rd_ptr];
         mem_wr_be_o   = ent_be[rd_ptr];
      end
   end

   // Word-granular match against every buffered entry, including the head being drained.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && (ent_addr[i] == ld_check_addr_i[31:2])) hit = 1'b1;
      end
      ld_hazard_o = ld_check_en_i && hit;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed + randomized bench for store_buffer, checked against a queue-based reference model.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          st_valid = 1'b0;
   logic          st_ready;
   logic [31:0]   st_addr = '0;
   logic [31:0]   st_data = '0;
   logic [1:0]    st_size = '0;
   logic          st_mis;
   logic          wr_en;
   logic [31:0]   wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_be;
   logic          wr_ready = 1'b0;
   logic          ld_en = 1'b0;
   logic [31:0]   ld_addr = '0;
   logic          hazard;
   logic          empty;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr),
      .st_data_i(st_data), .st_size_i(st_size), .st_misaligned_o(st_mis),
      .mem_wr_en_o(wr_en), .mem_wr_addr_o(wr_addr), .mem_wr_data_o(wr_data),
      .mem_wr_be_o(wr_be), .mem_wr_ready_i(wr_ready),
      .ld_check_en_i(ld_en), .ld_check_addr_i(ld_addr), .ld_hazard_o(hazard),
      .empty_o(empty), .count_o(count)
   );

   typedef struct packed {
      logic [29:0] w;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;

   ent_t q[$];
   bit   mis_exp = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Lane n carries byte (n - offset) of the store when it falls inside the access.
   function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] sz, output bit legal, output ent_t e);
      int nb;
      int off;
      nb    = 1 << sz;
      off   = int'(a[1:0]);
      legal = (sz != 2'd3) && ((off % nb) == 0);
      e.w   = a[31:2];
      e.d   = '0;
      e.be  = '0;
      for (int n = 0; n < 4; n++) begin
         if (n >= off && n < off + nb) begin
            e.be[n]      = 1'b1;
            e.d[8*n +: 8] = d[8*(n-off) +: 8];
         end
      end
   endfunction

   task automatic check_model();
      ent_t h;
      bit hz;
      h  = (q.size() > 0) ? q[0] : '0;
      hz = 1'b0;
      foreach (q[i]) if (q[i].w == ld_addr[31:2]) hz = 1'b1;
      hz = hz && ld_en;
      chk("count",   32'(count),    32'(q.size()));
      chk("empty",   32'(empty),    32'(q.size() == 0));
      chk("ready",   32'(st_ready), 32'(q.size() != DEPTH));
      chk("wr_en",   32'(wr_en),    32'(q.size() != 0));
      chk("wr_addr", wr_addr,       {h.w, 2'b00});
      chk("wr_data", wr_data,       h.d);
      chk("wr_be",   32'(wr_be),    32'(h.be));
      chk("mis",     32'(st_mis),   32'(mis_exp));
      chk("hazard",  32'(hazard),   32'(hz));
   endtask

   task automatic update_model();
      bit   acc;
      bit   legal;
      ent_t e;
      acc = st_valid && (q.size() < DEPTH);
      if (q.size() > 0 && wr_ready) void'(q.pop_front());
      model_store(st_addr, st_data, st_size, legal, e);
      if (acc && legal) q.push_back(e);
      mis_exp = acc && !legal;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_model();
      update_model();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz);
      st_valid = v;
      st_addr  = a;
      st_data  = d;
      st_size  = sz;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_count"}, 32'(count),    32'd0);
      chk({tag, "_empty"}, 32'(empty),    32'd1);
      chk({tag, "_ready"}, 32'(st_ready), 32'd1);
      chk({tag, "_mis"},   32'(st_mis),   32'd0);
      chk({tag, "_wr_en"}, 32'(wr_en),    32'd0);
      chk({tag, "_addr"},  wr_addr,       32'd0);
      chk({tag, "_data"},  wr_data,       32'd0);
      chk({tag, "_be"},    32'(wr_be),    32'd0);
      chk({tag, "_hz"},    32'(hazard),   32'd0);
   endtask

   initial begin
      // Reset and idle
      #12;
      check_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle();
      check_reset("idle");

      // Lane steering with the memory always ready
      wr_ready = 1'b1;
      drive(1'b1, 32'h1003, 32'h0000_00AB, 2'b00);
      cycle();
      drive(1'b0, '0, '0, 2'b00);
      chk("byte_en",   32'(wr_en), 32'd1);
      chk("byte_addr", wr_addr,    32'h1000);
      chk("byte_data", wr_data,    32'hAB00_0000);
      chk("byte_be",   32'(wr_be), 32'h8);
      cycle();
      drive(1'b1, 32'h2002, 32'h0000_BEEF, 2'b01);
      cycle();
      drive(1'b0, '0, '0, 2'b00);
      chk("half_addr", wr_addr,    32'h2000);
      chk("half_data", wr_data,    32'hBEEF_0000);
      chk("half_be",   32'(wr_be), 32'hC);
      cycle();
      drive(1'b1, 32'h3000, 32'h1234_5678, 2'b10);
      cycle();
      drive(1'b0, '0, '0, 2'b00);
      chk("word_addr", wr_addr,    32'h3000);
      chk("word_data", wr_data,    32'h1234_5678);
      chk("word_be",   32'(wr_be), 32'hF);
      cycle();

      // Misaligned and reserved stores are acknowledged but dropped
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       drive(1'b1, 32'h1001, 32'hDEAD_BEEF, 2'b10);
            1:       drive(1'b1, 32'h1005, 32'hDEAD_BEEF, 2'b01);
            default: drive(1'b1, 32'h1000, 32'hDEAD_BEEF, 2'b11);
         endcase
         chk("mis_hs_ready", 32'(st_ready), 32'd1);
         cycle();
         drive(1'b0, '0, '0, 2'b00);
         chk("mis_pulse", 32'(st_mis), 32'd1);
         chk("mis_count", 32'(count),  32'd0);
         chk("mis_wr_en", 32'(wr_en),  32'd0);
         cycle();
         chk("mis_clear", 32'(st_mis), 32'd0);
      end

      // Backpressure: fill to DEPTH, extra store is refused, then drain in order
      wr_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         drive(1'b1, 32'h5000 + 32'(16 * i), 32'hA000_0000 + 32'(i), 2'b10);
         cycle();
      end
      drive(1'b0, '0, '0, 2'b00);
      chk("full_ready", 32'(st_ready), 32'd0);
      chk("full_count", 32'(count),    32'(DEPTH));
      wr_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_addr", wr_addr, 32'h5000 + 32'(16 * i));
         chk("drain_data", wr_data, 32'hA000_0000 + 32'(i));
         cycle();
      end
      chk("drained", 32'(empty), 32'd1);
      wr_ready = 1'b0;
      drive(1'b1, 32'h6000, 32'h1111_1111, 2'b10);
      cycle();
      wr_ready = 1'b1;
      drive(1'b1, 32'h6004, 32'h2222_2222, 2'b10);
      cycle();
      drive(1'b0, '0, '0, 2'b00);
      chk("pushpop_count", 32'(count), 32'd1);
      chk("pushpop_head",  wr_addr,    32'h6004);
      cycle();

      // Load hazard detection
      wr_ready = 1'b0;
      drive(1'b1, 32'h400, 32'h5555_5555, 2'b10);
      cycle();
      drive(1'b0, '0, '0, 2'b00);
      ld_en = 1'b1;
      ld_addr = 32'h402;
      #1 chk("hz_same_word", 32'(hazard), 32'd1);
      ld_addr = 32'h404;
      #1 chk("hz_next_word", 32'(hazard), 32'd0);
      drive(1'b1, 32'h404, 32'h6666_6666, 2'b10);
      #1 chk("hz_incoming", 32'(hazard), 32'd0);
      cycle();
      drive(1'b0, '0, '0, 2'b00);
      ld_addr = 32'h402;
      wr_ready = 1'b1;
      #1 chk("hz_head_draining", 32'(hazard), 32'd1);
      cycle();
      #1 chk("hz_after_pop", 32'(hazard), 32'd0);
      cycle();
      ld_en = 1'b0;

      // Asynchronous reset while a store is draining
      wr_ready = 1'b0;
      drive(1'b1, 32'h7000, 32'h7777_7777, 2'b10);
      cycle();
      cycle();
      drive(1'b0, '0, '0, 2'b00);
      wr_ready = 1'b1;
      chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset("async");
      q.delete();
      mis_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized stress against the reference queue
      for (int i = 0; i < 10000; i++) begin
         st_valid = ($urandom_range(0, 99) < 60);
         st_addr  = 32'h100 + 32'($urandom_range(0, 31));
         st_data  = $urandom;
         st_size  = 2'($urandom_range(0, 3));
         wr_ready = ($urandom_range(0, 99) < 55);
         ld_en    = ($urandom_range(0, 99) < 50);
         ld_addr  = 32'h100 + 32'($urandom_range(0, 31));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
